// File: rtl/bms_float_pkg.sv
// Shared float constants, encoder state enum and a magnitude helper used on
// both sides of the 32-bit float interface between encoder and comparators.
package bms_float_pkg;

    localparam int FLOAT_BIAS   = 127;
    localparam int FLOAT_MANT_W = 23;
    localparam int FLOAT_EXP_W  = 8;

    // 85.125 degrees C as IEEE-754 single, matched against encoder output.
    localparam logic [31:0] TEMP_LIMIT_F32 = 32'h42AA4000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } enc_state_t;

    // Two's-complement magnitude; 0x80000000 maps onto itself as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] value);
        logic [31:0] result;
        if (value[31]) begin
            result = ~value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/float_round_pack.sv
// Packs a normalized magnitude into an IEEE-754 single word.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module float_round_pack
    import bms_float_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        sign,
    input  logic [31:0] mag,
    input  logic [4:0]  shift,
    output logic [31:0] word
);

    localparam logic signed [8:0] EXP_BASE = 9'(FLOAT_BIAS + 31 - FRAC_BITS);

    logic signed [8:0]         exp_raw_s;
    logic [FLOAT_EXP_W-1:0]    exp_s;
    logic [FLOAT_MANT_W-1:0]   mant_s;
    logic                      unused_s;

`ifdef ROUND_NEAREST_EN
    logic        guard_s;
    logic        sticky_s;
    logic        round_up_s;
    logic [23:0] mant_inc_s;

    // Round to nearest even; a carry out of the mantissa bumps the exponent.
    always_comb begin
        exp_raw_s  = EXP_BASE - $signed({4'b0000, shift});
        guard_s    = mag[7];
        sticky_s   = |mag[6:0];
        round_up_s = guard_s && (sticky_s || mag[8]);
        mant_inc_s = {1'b0, mag[30:8]} + {23'd0, round_up_s};
        if (mant_inc_s[23]) begin
            mant_s = 23'd0;
            exp_s  = exp_raw_s[7:0] + 8'd1;
        end else begin
            mant_s = mant_inc_s[22:0];
            exp_s  = exp_raw_s[7:0];
        end
        word = {sign, exp_s, mant_s};
    end

    assign unused_s = &{1'b0, mag[31], exp_raw_s[8]};
`else
    // Truncation: the bits below the mantissa are simply dropped.
    always_comb begin
        exp_raw_s = EXP_BASE - $signed({4'b0000, shift});
        mant_s    = mag[30:8];
        exp_s     = exp_raw_s[7:0];
        word      = {sign, exp_s, mant_s};
    end

    assign unused_s = &{1'b0, mag[31], mag[7:0], exp_raw_s[8]};
`endif

endmodule

// File: rtl/fixed_to_float_encoder.sv
// Signed Q(31-FRAC_BITS).FRAC_BITS to IEEE-754 single converter, one
// normalization bit per cycle. Rounding mode selected by ROUND_NEAREST_EN.
module fixed_to_float_encoder
    import bms_float_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    enc_state_t  state_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [4:0]  shift_r;
    logic [31:0] in_mag_s;
    logic [31:0] packed_s;

    assign in_mag_s = abs32(in_data);

    float_round_pack #(
        .FRAC_BITS (FRAC_BITS)
    ) u_round_pack (
        .sign  (sign_r),
        .mag   (mag_r),
        .shift (shift_r),
        .word  (packed_s)
    );

    // Handshake and normalization FSM; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= 32'd0;
            shift_r   <= 5'd0;
            out_data  <= 32'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_r   <= in_data[31];
                        mag_r    <= in_mag_s;
                        shift_r  <= 5'd0;
                        if (in_mag_s == 32'd0) begin
                            out_data <= 32'd0;
                            state_r  <= ST_OUT;
                        end else begin
                            state_r  <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (mag_r[31]) begin
                        state_r <= ST_ROUND;
                    end else begin
                        mag_r   <= {mag_r[30:0], 1'b0};
                        shift_r <= shift_r + 5'd1;
                    end
                end
                ST_ROUND: begin
                    out_data  <= packed_s;
                    out_valid <= 1'b1;
                    state_r   <= ST_OUT;
                end
                ST_OUT: begin
                    // The zero shortcut enters OUT one cycle early, so valid rises here.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
